// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, MDU results queue in a small FIFO.
// Optional direct MDU-to-port path when the FIFO is idle: define WBARB_BYPASS_EN.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_regwrite,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] fifo_addr_reg [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_reg [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_next     [FIFO_DEPTH];
  logic [DATA_W-1:0] data_next     [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [STV_W-1:0]  starve_reg, starve_next;
  logic              stall_next;

  logic              fifo_empty;
  logic              pipe_grant;
  logic              fifo_pop;
  logic              bypass_grant;
  logic              push_req;
  logic              squash;
  logic              head_squash;
  logic              grant;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic [CNT_W-1:0]  kept;

  // Entries viewed in FIFO order (oldest first), with a flag saying they survive a squash.
  logic [PTR_W-1:0]  ord_idx  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ord_keep;

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_order
      assign ord_idx[gi]  = rd_ptr_reg + PTR_W'(gi);
      assign ord_keep[gi] = (CNT_W'(gi) < count_reg) && (fifo_addr_reg[ord_idx[gi]] != wb_addr);
    end
  endgenerate

  assign fifo_empty = (count_reg == '0);
  assign mdu_ready  = (count_reg < CNT_W'(FIFO_DEPTH));
  assign pipe_grant = wb_regwrite & ~pipe_stall;
  assign fifo_pop   = ~fifo_empty & (pipe_stall | ~wb_regwrite);

`ifdef WBARB_BYPASS_EN
  assign bypass_grant = fifo_empty & ~pipe_grant & ~pipe_stall & mdu_valid;
`else
  assign bypass_grant = 1'b0;
`endif

  assign push_req    = mdu_valid & mdu_ready & ~bypass_grant;
  assign squash      = pipe_grant & (wb_addr != '0);
  assign head_squash = squash & ~fifo_empty & (fifo_addr_reg[rd_ptr_reg] == wb_addr);

  always_comb begin
    grant      = 1'b0;
    grant_addr = rf_addr;
    grant_data = rf_wdata;
    if (fifo_pop) begin
      grant      = 1'b1;
      grant_addr = fifo_addr_reg[rd_ptr_reg];
      grant_data = fifo_data_reg[rd_ptr_reg];
    end else if (pipe_grant) begin
      grant      = 1'b1;
      grant_addr = wb_addr;
      grant_data = wb_data;
    end else if (bypass_grant) begin
      grant      = 1'b1;
      grant_addr = mdu_addr;
      grant_data = mdu_data;
    end
  end

  // A squash compacts the survivors (and any same-cycle push) to the front of the buffer.
  always_comb begin
    addr_next   = fifo_addr_reg;
    data_next   = fifo_data_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    kept        = '0;
    if (squash) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        if (ord_keep[k]) begin
          addr_next[kept[PTR_W-1:0]] = fifo_addr_reg[ord_idx[k]];
          data_next[kept[PTR_W-1:0]] = fifo_data_reg[ord_idx[k]];
          kept = kept + CNT_W'(1);
        end
      end
      if (push_req && (mdu_addr != wb_addr)) begin
        addr_next[kept[PTR_W-1:0]] = mdu_addr;
        data_next[kept[PTR_W-1:0]] = mdu_data;
        kept = kept + CNT_W'(1);
      end
      rd_ptr_next = '0;
      wr_ptr_next = kept[PTR_W-1:0];
      count_next  = kept;
    end else begin
      if (fifo_pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      if (push_req) begin
        addr_next[wr_ptr_reg] = mdu_addr;
        data_next[wr_ptr_reg] = mdu_data;
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      count_next = count_reg + CNT_W'(push_req) - CNT_W'(fifo_pop);
    end
  end

  // Any cycle the head is neither popped nor squashed it was denied by a pipeline grant.
  always_comb begin
    starve_next = starve_reg;
    stall_next  = 1'b0;
    if (fifo_empty || fifo_pop || head_squash) begin
      starve_next = '0;
    end else if (starve_reg == STV_W'(STARVE_LIMIT - 1)) begin
      starve_next = '0;
      stall_next  = 1'b1;
    end else begin
      starve_next = starve_reg + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    fifo_addr_reg <= addr_next;
    fifo_data_reg <= data_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_addr    <= '0;
      rf_wdata   <= '0;
      pipe_stall <= 1'b0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
    end else begin
      rf_we      <= grant && (grant_addr != '0);
      if (grant) begin
        rf_addr  <= grant_addr;
        rf_wdata <= grant_data;
      end
      pipe_stall <= stall_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      starve_reg <= starve_next;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table with a scoreboard queue plus an async-reset sequence.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_regwrite;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          mdu_valid;
  logic [AW-1:0] mdu_addr;
  logic [DW-1:0] mdu_data;
  logic          mdu_ready;
  logic          pipe_stall;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_regwrite(wb_regwrite), .wb_addr(wb_addr), .wb_data(wb_data),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata)
  );

  typedef struct {
    logic          rw;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          we;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          st;
    logic          rdy;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          st;
    logic          rdy;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input int rw, input int wa, input int wd, input int mv, input int ma,
                              input int md, input int we, input int ea, input int ed, input int st,
                              input int rdy);
    vec_t v;
    v.rw = 1'(rw);  v.wa = AW'(wa); v.wd = DW'(wd);
    v.mv = 1'(mv);  v.ma = AW'(ma); v.md = DW'(md);
    v.we = 1'(we);  v.ea = AW'(ea); v.ed = DW'(ed);
    v.st = 1'(st);  v.rdy = 1'(rdy);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wb_regwrite = v.rw; wb_addr = v.wa; wb_data = v.wd;
    mdu_valid   = v.mv; mdu_addr = v.ma; mdu_data = v.md;
  endtask

  task automatic step_pipe(input int a, input int d, input int mv, input int ma, input int md);
    drive(mk(1, a, d, mv, ma, md, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    // Pipeline only
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 0,          0, 1));
    tbl.push_back(mk(1, 5, 'hFFFFFFF6, 0, 0, 0,      1, 5, 'hFFFFFFF6, 0, 1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 0,          0, 1));
    // MDU idle path
`ifdef WBARB_BYPASS_EN
    tbl.push_back(mk(0, 0, 0,          1, 9, 'h1234, 1, 9, 'h1234,     0, 1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 0,          0, 1));
`else
    tbl.push_back(mk(0, 0, 0,          1, 9, 'h1234, 0, 0, 0,          0, 1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      1, 9, 'h1234,     0, 1));
`endif
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 0,          0, 1));
    // Starvation: addr 7 waits behind four pipeline writes, then a forced stall
    tbl.push_back(mk(1, 1, 'h101,      1, 7, 'h77,   1, 1, 'h101,      0, 1));
    tbl.push_back(mk(1, 2, 'h102,      0, 0, 0,      1, 2, 'h102,      0, 1));
    tbl.push_back(mk(1, 3, 'h103,      0, 0, 0,      1, 3, 'h103,      0, 1));
    tbl.push_back(mk(1, 4, 'h104,      0, 0, 0,      1, 4, 'h104,      0, 1));
    tbl.push_back(mk(1, 6, 'h106,      0, 0, 0,      1, 6, 'h106,      1, 1));
    tbl.push_back(mk(1, 8, 'h108,      0, 0, 0,      1, 7, 'h77,       0, 1));
    tbl.push_back(mk(1, 8, 'h108,      0, 0, 0,      1, 8, 'h108,      0, 1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 0,          0, 1));
    // Full / backpressure: third MDU result held until a pop frees a slot
    tbl.push_back(mk(1, 10, 'h1,       1, 20, 'hA0,  1, 10, 'h1,       0, 1));
    tbl.push_back(mk(1, 11, 'h2,       1, 21, 'hA1,  1, 11, 'h2,       0, 0));
    tbl.push_back(mk(1, 13, 'h3,       1, 22, 'hA2,  1, 13, 'h3,       0, 0));
    tbl.push_back(mk(1, 14, 'h4,       1, 22, 'hA2,  1, 14, 'h4,       0, 0));
    tbl.push_back(mk(1, 15, 'h5,       1, 22, 'hA2,  1, 15, 'h5,       1, 0));
    tbl.push_back(mk(1, 16, 'h6,       1, 22, 'hA2,  1, 20, 'hA0,      0, 1));
    tbl.push_back(mk(1, 16, 'h6,       1, 22, 'hA2,  1, 16, 'h6,       0, 0));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      1, 21, 'hA1,      0, 1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      1, 22, 'hA2,      0, 1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 0,          0, 1));
    // Squash of a queued addr 12, then a pipeline write to register 0
    tbl.push_back(mk(1, 1, 'h201,      1, 12, 'hC0,  1, 1, 'h201,      0, 1));
    tbl.push_back(mk(1, 12, 'h12,      0, 0, 0,      1, 12, 'h12,      0, 1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 0,          0, 1));
    tbl.push_back(mk(1, 0, 'hDEAD,     0, 0, 0,      0, 0, 0,          0, 1));
    tbl.push_back(mk(0, 0, 0,          0, 0, 0,      0, 0, 0,          0, 1));

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #12;
    chk("reset_rf_we",      32'(rf_we),      32'd0);
    chk("reset_rf_addr",    32'(rf_addr),    32'd0);
    chk("reset_rf_wdata",   rf_wdata,        32'd0);
    chk("reset_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("reset_mdu_ready",  32'(mdu_ready),  32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      sb.push_back('{we: tbl[i].we, ea: tbl[i].ea, ed: tbl[i].ed, st: tbl[i].st, rdy: tbl[i].rdy});
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_rf_we", i),      32'(rf_we),      32'(e.we));
      chk($sformatf("v%0d_pipe_stall", i), 32'(pipe_stall), 32'(e.st));
      chk($sformatf("v%0d_mdu_ready", i),  32'(mdu_ready),  32'(e.rdy));
      if (e.we) begin
        chk($sformatf("v%0d_rf_addr", i),  32'(rf_addr),    32'(e.ea));
        chk($sformatf("v%0d_rf_wdata", i), rf_wdata,        e.ed);
      end
      $display("vec %0d: rw=%0b wa=%0d mv=%0b ma=%0d -> we=%0b addr=%0d data=0x%08h stall=%0b ready=%0b",
               i, tbl[i].rw, tbl[i].wa, tbl[i].mv, tbl[i].ma, rf_we, rf_addr, rf_wdata, pipe_stall, mdu_ready);
    end

    // Async reset with two queued entries while the forced stall is active
    step_pipe(1, 'h301, 1, 20, 'hB0);
    step_pipe(2, 'h302, 1, 21, 'hB1);
    step_pipe(3, 'h303, 0, 0, 0);
    step_pipe(4, 'h304, 0, 0, 0);
    step_pipe(5, 'h305, 0, 0, 0);
    chk("pre_reset_pipe_stall", 32'(pipe_stall), 32'd1);
    chk("pre_reset_mdu_ready",  32'(mdu_ready),  32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rf_we",      32'(rf_we),      32'd0);
    chk("async_rf_addr",    32'(rf_addr),    32'd0);
    chk("async_rf_wdata",   rf_wdata,        32'd0);
    chk("async_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("async_mdu_ready",  32'(mdu_ready),  32'd1);
    $display("async reset applied mid-stream");
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_reset_c%0d_rf_we", c),      32'(rf_we),      32'd0);
      chk($sformatf("post_reset_c%0d_pipe_stall", c), 32'(pipe_stall), 32'd0);
      $display("post-reset cycle %0d: we=%0b stall=%0b ready=%0b", c, rf_we, pipe_stall, mdu_ready);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
